branch_predict_ctrl: RTL and testbench



---
 rtl/branch_predict_ctrl.sv | 117 +++++++++++
 tb/tb_branch_predict_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor: a table of 2-bit saturating counters, swept to weakly-not-taken after reset.
// Optional gshare indexing (global history XOR PC) is enabled by defining BPRED_GSHARE_EN.
module branch_predict_ctrl #(
  parameter int IDX_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  output logic                ready,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  output logic [CNT_BITS-1:0] mispredict_cnt
);

  localparam int DEPTH = 2 ** IDX_BITS;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          pht_q [DEPTH];

  logic                pht_we;
  logic [IDX_BITS-1:0] pht_waddr;
  logic [1:0]          pht_wdata;
  logic [1:0]          upd_old;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

`ifdef BPRED_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q, ghr_d;
  assign pred_idx = pred_pc[IDX_BITS+1:2] ^ ghr_q;
`else
  assign pred_idx = pred_pc[IDX_BITS+1:2];
`endif

  // Combinational read of the registered table; a same-cycle update is not bypassed.
  assign ready          = (state_q == RUN);
  assign pred_taken     = ready & pht_q[pred_idx][1];
  assign mispredict_cnt = cnt_q;
  assign upd_old        = pht_q[upd_idx];

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    cnt_d      = cnt_q;
    pht_we     = 1'b0;
    pht_waddr  = init_ptr_q;
    pht_wdata  = 2'b01;
`ifdef BPRED_GSHARE_EN
    ghr_d      = ghr_q;
`endif
    case (state_q)
      INIT: begin
        pht_we     = 1'b1;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == {IDX_BITS{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (upd_valid) begin
          pht_we    = 1'b1;
          pht_waddr = upd_idx;
          if (upd_taken) begin
            pht_wdata = (upd_old == 2'b11) ? 2'b11 : upd_old + 2'b01;
          end else begin
            pht_wdata = (upd_old == 2'b00) ? 2'b00 : upd_old - 2'b01;
          end
`ifdef BPRED_GSHARE_EN
          ghr_d = {ghr_q[IDX_BITS-2:0], upd_taken};
`endif
          if (upd_mispredict && (cnt_q != {CNT_BITS{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      cnt_q      <= '0;
`ifdef BPRED_GSHARE_EN
      ghr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      cnt_q      <= cnt_d;
`ifdef BPRED_GSHARE_EN
      ghr_q      <= ghr_d;
`endif
    end
  end

  // Table has no reset of its own; the INIT sweep defines every entry.
  always_ff @(posedge clk) begin
    if (!rst && pht_we) begin
      pht_q[pht_waddr] <= pht_wdata;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl (default bimodal build; gshare-aware indexing).
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pred_pc = '0;
  logic        pred_taken, ready, sat_pred_taken, sat_ready;
  logic [4:0]  pred_idx, sat_pred_idx;
  logic        upd_valid = 1'b0;
  logic [4:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [15:0] mispredict_cnt;
  logic [1:0]  sat_cnt;
  logic [4:0]  ghr_m = '0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_BITS(5), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_idx(pred_idx), .ready(ready), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .mispredict_cnt(mispredict_cnt)
  );

  branch_predict_ctrl #(.IDX_BITS(5), .CNT_BITS(2)) dut_sat (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(sat_pred_taken),
    .pred_idx(sat_pred_idx), .ready(sat_ready), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .mispredict_cnt(sat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
      $display("check %-16s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Choose a PC whose effective index equals idx under the current history.
  task automatic predict(input logic [4:0] idx);
    pred_pc = {25'b0, idx ^ ghr_m, 2'b00};
    #2;
  endtask

  task automatic upd(input logic [4:0] idx, input logic tk, input logic mis);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = tk; upd_mispredict = mis;
    step();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
`ifdef BPRED_GSHARE_EN
    ghr_m = {ghr_m[3:0], tk};
`endif
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk(tag, n, exp_cycles);
  endtask

  initial begin
    // Reset: two cycles high
    step();
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_cnt", {16'b0, mispredict_cnt}, 0);
    step();
    rst = 1'b0;
    ghr_m = '0;
    wait_ready("init_len", 32);
    pred_pc = 32'h40;
    #2;
    chk("init_idx", {27'b0, pred_idx}, 16);
    chk("init_taken", {31'b0, pred_taken}, 0);

    // Saturate up on idx 16
    upd(5'd16, 1'b1, 1'b0);
    predict(5'd16);
    chk("up1_taken", {31'b0, pred_taken}, 1);
    upd(5'd16, 1'b1, 1'b0);
    upd(5'd16, 1'b1, 1'b0);
    upd(5'd16, 1'b0, 1'b0);
    predict(5'd16);
    chk("up_nt1_taken", {31'b0, pred_taken}, 1);
    upd(5'd16, 1'b0, 1'b0);
    predict(5'd16);
    chk("up_nt2_taken", {31'b0, pred_taken}, 0);

    // Saturate down on idx 5
    upd(5'd5, 1'b0, 1'b0);
    upd(5'd5, 1'b0, 1'b0);
    upd(5'd5, 1'b0, 1'b0);
    predict(5'd5);
    chk("dn3_taken", {31'b0, pred_taken}, 0);
    upd(5'd5, 1'b1, 1'b0);
    predict(5'd5);
    chk("dn_t1_taken", {31'b0, pred_taken}, 0);
    upd(5'd5, 1'b1, 1'b0);
    predict(5'd5);
    chk("dn_t2_taken", {31'b0, pred_taken}, 1);

    // Same-cycle predict and update on idx 7: no bypass
    predict(5'd7);
    upd_valid = 1'b1; upd_idx = 5'd7; upd_taken = 1'b1;
    #1;
    chk("haz_same", {31'b0, pred_taken}, 0);
    step();
    upd_valid = 1'b0;
`ifdef BPRED_GSHARE_EN
    ghr_m = {ghr_m[3:0], 1'b1};
`endif
    predict(5'd7);
    chk("haz_next", {31'b0, pred_taken}, 1);

    // Mispredict counters (16-bit and saturating 2-bit instance)
    upd(5'd9, 1'b1, 1'b1);
    chk("mis1_cnt", {16'b0, mispredict_cnt}, 1);
    chk("mis1_sat", {30'b0, sat_cnt}, 1);
    upd(5'd9, 1'b1, 1'b0);
    chk("mis_nomis_cnt", {16'b0, mispredict_cnt}, 1);
    upd(5'd9, 1'b1, 1'b1);
    upd(5'd9, 1'b1, 1'b1);
    upd(5'd9, 1'b1, 1'b1);
    chk("mis4_cnt", {16'b0, mispredict_cnt}, 4);
    chk("mis4_sat", {30'b0, sat_cnt}, 3);
    upd(5'd9, 1'b0, 1'b1);
    chk("mis5_sat", {30'b0, sat_cnt}, 3);

    // Train idx 3 to strongly taken, then reset mid-run
    upd(5'd3, 1'b1, 1'b0);
    upd(5'd3, 1'b1, 1'b0);
    predict(5'd3);
    chk("tr3_taken", {31'b0, pred_taken}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ghr_m = '0;
    pred_pc = 32'h0C;
    #1;
    chk("re_ready", {31'b0, ready}, 0);
    chk("re_cnt", {16'b0, mispredict_cnt}, 0);
    for (int i = 0; i < 10; i++) begin
      upd_valid = 1'b1; upd_idx = 5'd3; upd_taken = 1'b1; upd_mispredict = 1'b1;
      #1;
      if (i == 5) chk("re_init_taken", {31'b0, pred_taken}, 0);
      step();
    end
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    wait_ready("reinit_len", 22);
    pred_pc = 32'h0C;
    #2;
    chk("re3_taken", {31'b0, pred_taken}, 0);
    chk("re_cnt_run", {16'b0, mispredict_cnt}, 0);
    chk("re_sat_run", {30'b0, sat_cnt}, 0);

    // History pattern T,NT,T: gshare gives 16^5, bimodal stays 16
    upd(5'd20, 1'b1, 1'b0);
    upd(5'd20, 1'b0, 1'b0);
    upd(5'd20, 1'b1, 1'b0);
    pred_pc = 32'h40;
    #2;
`ifdef BPRED_GSHARE_EN
    chk("gs_idx", {27'b0, pred_idx}, 21);
`else
    chk("gs_idx", {27'b0, pred_idx}, 16);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
